seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU: WIDTH-bit successor of the single-cycle 32-bit ALU.
//  Keeps the AND/OR/ADD/SUB/SLT/NOR control codes.
//  Adds XOR, unsigned multiply (low half), unsigned divide and remainder. Multiply and divide are
//  iterative (one bit per cycle). Operands and results move through valid/ready handshakes.
//  Sits between the register-read stage and write-back of the multi-cycle CPU datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range 4..64
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      a, b, ALU_ctl valid this cycle
//  in_ready   out  1      block can accept an operation
//  a          in   WIDTH  source 1
//  b          in   WIDTH  source 2
//  ALU_ctl    in   4      operation select
//  out_valid  out  1      result, zero, overflow valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  operation result
//  zero       out  1      1 when result == 0
//  overflow   out  1      signed overflow; ADD/SUB only
// BEHAVIOUR
//  One clock (clk). Reset is synchronous, active-high (rst).
//  Reset: state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; overflow=0. Counters and partial products/remainders are cleared.
//  ALU_ctl codes:
//   0000 AND
//   0001 OR
//   0010 ADD
//   0011 XOR
//   0110 SUB
//   0111 SLT (signed a<b -> 1 else 0)
//   1100 NOR
//   1000 MUL (low WIDTH bits of unsigned a*b)
//   1010 DIVU
//   1011 REMU
//   Any other code: result=0, overflow=0.
//  All arithmetic is modulo 2^WIDTH.
//   overflow=1 only for ADD/SUB with signed overflow (operand signs agree; result sign differs). For SUB, compare against ~b.
//   SLT uses the true signed compare, correct even when a-b overflows; SLT overflow=0.
//  States IDLE, BUSY, DONE.
//   IDLE: in_ready=1. Accept when in_valid&&in_ready; operands and ALU_ctl are latched.
//     Simple op (AND/OR/ADD/XOR/SUB/SLT/NOR/illegal): result computed and registered -> DONE.
//     MUL/DIVU/REMU: load iteration registers, cnt=0 -> BUSY.
//   BUSY: in_ready=0. One shift-add (MUL) or restoring-division step per cycle.
//     After WIDTH steps (cnt==WIDTH-1): register result -> DONE.
//   DONE: out_valid=1; result/zero/overflow held stable until out_ready=1, then -> IDLE.
//     in_ready=0 in DONE. No new accept in the same cycle as the out_ready handshake.
//  Latency, accept edge to out_valid=1:
//   simple ops: 1 cycle
//   MUL/DIVU/REMU: WIDTH+1 cycles
//   Throughput: one op per 2 cycles minimum.
//  Divide by zero: DIVU result = all ones; REMU result = a. Takes the full WIDTH+1 latency; no error flag.
//  zero is derived from the registered result only, and is valid whenever out_valid=1.
//  Inputs a/b/ALU_ctl are ignored outside the accept cycle; changes mid-BUSY have no effect.
//  in_valid while BUSY/DONE: ignored. The producer must hold it until in_ready.
//  rst in any state (including mid-BUSY): abort immediately, return to reset values next edge. No result is emitted.
// TESTING
//  T1 WIDTH=32: ADD a=32'h7FFF_FFFF b=1 -> out_valid 1 cycle after accept; result=32'h8000_0000, overflow=1, zero=0.
//  T2 SLT a=-5 b=3 -> result=1. SLT a=32'h8000_0000 b=1 -> result=1, overflow=0. SUB a=b=32'h1234 -> result=0, zero=1.
//  T3 MUL a=32'h0001_0000 b=32'h0001_0000 -> out_valid exactly 33 cycles after accept; result=0, zero=1. MUL 1234*5678 -> 7006652.
//  T4 DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 55/0 -> 32'hFFFF_FFFF; REMU 55/0 -> 55. Each at 33-cycle latency.
//  T5 Backpressure: ADD 3+4, hold out_ready=0 for 5 cycles -> result=7 stable, out_valid=1, in_ready=0. Release -> IDLE next cycle.
//  T6 Reset mid-MUL: assert rst at BUSY cycle 10 -> next edge out_valid=0, in_ready=1, result=0. A new ADD 1+1 after reset -> 2.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result valid-ready bundle for seq_alu.
// master drives operands and takes results; slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALU_ctl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, ALU_ctl, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, ALU_ctl, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic ops, iterative MUL/DIVU/REMU.
// One bit per BUSY cycle; results held in DONE until taken.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_DIVU = 4'b1010;
  localparam logic [3:0] C_REMU = 4'b1011;

  localparam logic [1:0] K_MUL = 2'd0;
  localparam logic [1:0] K_DIV = 2'd1;
  localparam logic [1:0] K_REM = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [CW-1:0]    cnt;
  logic [1:0]       kind;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;
  logic             is_long;
  logic [1:0]       kind_in;

  logic [WIDTH-1:0] acc_m;
  logic [WIDTH-1:0] shifted;
  logic             ge;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] res_l;
  logic             last;
  logic             in_ready;
  logic             out_valid;
  logic             accept;

  always_comb begin
    sum   = bus.a + bus.b;
    diff  = bus.a - bus.b;
    res_s = '0;
    ovf_s = 1'b0;
    case (bus.ALU_ctl)
      C_AND: res_s = bus.a & bus.b;
      C_OR:  res_s = bus.a | bus.b;
      C_XOR: res_s = bus.a ^ bus.b;
      C_NOR: res_s = ~(bus.a | bus.b);
      C_ADD: begin
        res_s = sum;
        ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
             && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      C_SUB: begin
        res_s = diff;
        ovf_s = (bus.a[WIDTH-1] == ~bus.b[WIDTH-1])
             && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      C_SLT: res_s = {{(WIDTH-1){1'b0}},
                      $signed(bus.a) < $signed(bus.b)};
      default: ;
    endcase
  end

  always_comb begin
    is_long = 1'b0;
    kind_in = K_MUL;
    case (bus.ALU_ctl)
      C_MUL:  is_long = 1'b1;
      C_DIVU: begin
        is_long = 1'b1;
        kind_in = K_DIV;
      end
      C_REMU: begin
        is_long = 1'b1;
        kind_in = K_REM;
      end
      default: ;
    endcase
  end

  // acc: product (MUL) or partial remainder (DIV/REM)
  // x:   multiplicand (MUL) or dividend/quotient (DIV/REM)
  // y:   multiplier (MUL) or divisor (DIV/REM)
  always_comb begin
    acc_m   = acc + (y[0] ? x : '0);
    shifted = {acc[WIDTH-2:0], x[WIDTH-1]};
    ge      = acc[WIDTH-1] | (shifted >= y);
    acc_d   = shifted - (ge ? y : '0);
    x_d     = {x[WIDTH-2:0], ge};
    last    = (cnt == CW'(WIDTH - 1));
    res_l   = acc_m;
    if (kind == K_DIV) res_l = x_d;
    if (kind == K_REM) res_l = acc_d;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (bus.in_valid) state_nx = is_long ? BUSY : DONE;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      kind     <= K_MUL;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      if (is_long) begin
        acc  <= '0;
        x    <= bus.a;
        y    <= bus.b;
        cnt  <= '0;
        kind <= kind_in;
      end else begin
        result_q <= res_s;
        zero_q   <= (res_s == '0);
        ovf_q    <= ovf_s;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (kind == K_MUL) begin
        acc <= acc_m;
        x   <= x << 1;
        y   <= y >> 1;
      end else begin
        acc <= acc_d;
        x   <= x_d;
      end
      if (last) begin
        result_q <= res_l;
        zero_q   <= (res_l == '0);
        ovf_q    <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=32.
// Table of ops plus backpressure and mid-BUSY reset sequences.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one op, measure accept->out_valid latency, check, then drain.
  task automatic run_op(input string name,
                        input logic [3:0] ctl,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] res,
                        input logic z,
                        input logic o,
                        input int lat);
    int n;
    int lt;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.ALU_ctl  = ctl;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0BAD_F00D;
    bus.ALU_ctl  = 4'b0010;
    lt = 1;
    while (bus.out_valid !== 1'b1 && lt < 200) begin
      @(posedge clk);
      #1;
      lt++;
    end
    check({name, " latency"}, 64'(lt), 64'(lat));
    check({name, " result"}, 64'(bus.result), 64'(res));
    check({name, " zero"}, 64'(bus.zero), 64'(z));
    check({name, " ovf"}, 64'(bus.overflow), 64'(o));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ALU_ctl   = '0;
    bus.out_ready = 1'b0;

    vt.push_back('{"add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1,
                   32'h8000_0000, 1'b0, 1'b1, 1});
    vt.push_back('{"slt_neg", 4'b0111, 32'hFFFF_FFFB, 32'h3,
                   32'h1, 1'b0, 1'b0, 1});
    vt.push_back('{"slt_min", 4'b0111, 32'h8000_0000, 32'h1,
                   32'h1, 1'b0, 1'b0, 1});
    vt.push_back('{"slt_false", 4'b0111, 32'h3, 32'hFFFF_FFFB,
                   32'h0, 1'b1, 1'b0, 1});
    vt.push_back('{"sub_eq", 4'b0110, 32'h1234, 32'h1234,
                   32'h0, 1'b1, 1'b0, 1});
    vt.push_back('{"sub_ovf", 4'b0110, 32'h8000_0000, 32'h1,
                   32'h7FFF_FFFF, 1'b0, 1'b1, 1});
    vt.push_back('{"add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,
                   32'h0, 1'b1, 1'b0, 1});
    vt.push_back('{"and", 4'b0000, 32'hF0F0_FF00, 32'h0FF0_0FF0,
                   32'h00F0_0F00, 1'b0, 1'b0, 1});
    vt.push_back('{"or", 4'b0001, 32'hF0F0_FF00, 32'h0FF0_0FF0,
                   32'hFFF0_FFF0, 1'b0, 1'b0, 1});
    vt.push_back('{"xor", 4'b0011, 32'hF0F0_FF00, 32'h0FF0_0FF0,
                   32'hFF00_F0F0, 1'b0, 1'b0, 1});
    vt.push_back('{"nor", 4'b1100, 32'h0, 32'h0,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 1});
    vt.push_back('{"illegal", 4'b0101, 32'h5, 32'h3,
                   32'h0, 1'b1, 1'b0, 1});
    vt.push_back('{"mul_hi", 4'b1000, 32'h0001_0000, 32'h0001_0000,
                   32'h0, 1'b1, 1'b0, 33});
    vt.push_back('{"mul", 4'b1000, 32'd1234, 32'd5678,
                   32'd7006652, 1'b0, 1'b0, 33});
    vt.push_back('{"mul_ones", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h1, 1'b0, 1'b0, 33});
    vt.push_back('{"divu", 4'b1010, 32'd100, 32'd7,
                   32'd14, 1'b0, 1'b0, 33});
    vt.push_back('{"remu", 4'b1011, 32'd100, 32'd7,
                   32'd2, 1'b0, 1'b0, 33});
    vt.push_back('{"divu_z", 4'b1010, 32'd55, 32'd0,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"remu_z", 4'b1011, 32'd55, 32'd0,
                   32'd55, 1'b0, 1'b0, 33});
    vt.push_back('{"divu_big", 4'b1010, 32'hFFFF_FFFF, 32'h1,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 33});
    vt.push_back('{"remu_big", 4'b1011, 32'hFFFF_FFFF, 32'h10,
                   32'hF, 1'b0, 1'b0, 33});
    vt.push_back('{"divu_top", 4'b1010, 32'hFFFF_FFFF, 32'h8000_0000,
                   32'h1, 1'b0, 1'b0, 33});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst zero", 64'(bus.zero), 64'd1);
    check("rst ovf", 64'(bus.overflow), 64'd0);

    foreach (vt[i]) begin
      run_op(vt[i].name, vt[i].ctl, vt[i].a, vt[i].b,
             vt[i].res, vt[i].z, vt[i].o, vt[i].lat);
    end

    // Backpressure: result held, new requests ignored while DONE.
    bus.in_valid = 1'b1;
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    bus.ALU_ctl  = 4'b0010;
    @(posedge clk);
    #1;
    bus.a = 32'd100;
    bus.b = 32'd100;
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      check("bp result", 64'(bus.result), 64'd7);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp release valid", 64'(bus.out_valid), 64'd0);
    check("bp release ready", 64'(bus.in_ready), 64'd1);

    // Reset while a multiply is in flight.
    bus.in_valid = 1'b1;
    bus.a        = 32'd1234;
    bus.b        = 32'd5678;
    bus.ALU_ctl  = 4'b1000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort result", 64'(bus.result), 64'd0);
    check("abort zero", 64'(bus.zero), 64'd1);
    run_op("post_rst_add", 4'b0010, 32'd1, 32'd1,
           32'd2, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
